// File: rtl/avalon_rr_arbiter.sv
// rtl/avalon_rr_arbiter.sv - round-robin arbiter for one Avalon slave port
// Grants one master at a time, holds through wait-request, rotates after a transfer quantum.
module avalon_rr_arbiter #(
  parameter int NUM_INPUTS   = 2,
  parameter int SEL_NUM_BITS = 5,
  parameter int SEL_VAL      = 0,
  parameter int MAX_XFERS    = 4
) (
  input  logic                                i_Clk,
  input  logic                                i_Reset,
  input  logic [30*NUM_INPUTS-1:0]            i_AVIn_Addr,
  input  logic [NUM_INPUTS-1:0]               i_AVIn_Read,
  input  logic [NUM_INPUTS-1:0]               i_AVIn_Write,
  input  logic                                i_AVOut_WaitRequest,
  output logic [$clog2(NUM_INPUTS+1)-1:0]     o_MuxSel,
  output logic [NUM_INPUTS-1:0]               o_Grant,
  output logic                                o_Busy
);

  localparam int SW = $clog2(NUM_INPUTS + 1);
  localparam logic [SW-1:0] NONE = SW'(NUM_INPUTS);

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         grant_q, grant_d;
  logic [SW-1:0]         last_q, last_d;
  logic [NUM_INPUTS-1:0] grant_oh_q, grant_oh_d;
  logic [7:0]            cnt_q, cnt_d, cnt_inc;
  logic [NUM_INPUTS-1:0] elig;
  logic [SW-1:0]         win_idx, excl_idx;
  logic                  win_found, g_elig, done;
  logic                  addr_unused;

  // Only the decode bits of each address matter here.
  assign addr_unused = ^i_AVIn_Addr;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      elig[k] = (i_AVIn_Read[k] | i_AVIn_Write[k]) &&
                (i_AVIn_Addr[30*k+29 -: SEL_NUM_BITS] == SEL_NUM_BITS'(SEL_VAL));
    end
  end

  // Two-pass scan: indices above last_q first, then wrap around to 0..last_q.
  always_comb begin
    excl_idx  = (state_q == S_GRANTED) ? grant_q : NONE;
    win_found = 1'b0;
    win_idx   = NONE;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!win_found && elig[i] && (SW'(i) > last_q) && (SW'(i) != excl_idx)) begin
        win_found = 1'b1;
        win_idx   = SW'(i);
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!win_found && elig[i] && (SW'(i) <= last_q) && (SW'(i) != excl_idx)) begin
        win_found = 1'b1;
        win_idx   = SW'(i);
      end
    end
  end

  assign g_elig  = |(elig & grant_oh_q);
  assign done    = (state_q == S_GRANTED) && g_elig && !i_AVOut_WaitRequest;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANTED;
          grant_d = win_idx;
          last_d  = win_idx;
          cnt_d   = 8'd0;
        end
      end
      S_GRANTED: begin
        if (done) begin
          if ((cnt_inc >= 8'(MAX_XFERS)) && win_found) begin
            grant_d = win_idx;
            last_d  = win_idx;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!g_elig) begin
          cnt_d = 8'd0;
          if (win_found) begin
            grant_d = win_idx;
            last_d  = win_idx;
          end else begin
            state_d = S_IDLE;
            grant_d = NONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = NONE;
      end
    endcase
    grant_oh_d = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      grant_oh_d[k] = (grant_d == SW'(k));
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      grant_q    <= NONE;
      last_q     <= SW'(NUM_INPUTS - 1);
      cnt_q      <= 8'd0;
      grant_oh_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      grant_oh_q <= grant_oh_d;
    end
  end

  assign o_MuxSel = grant_q;
  assign o_Grant  = grant_oh_q;
  assign o_Busy   = (state_q == S_GRANTED);

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// tb/tb_avalon_rr_arbiter.sv - scoreboard bench for avalon_rr_arbiter
// Two instances (2 masters/quantum 4, 3 masters/quantum 1) against a queue-fed reference model.
module tb_avalon_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [59:0] addr2;
  logic [1:0]  rd2, wr2;
  logic        wt2;
  logic [1:0]  sel2;
  logic [1:0]  gnt2;
  logic        busy2;
  logic [89:0] addr3;
  logic [2:0]  rd3, wr3;
  logic        wt3;
  logic [1:0]  sel3;
  logic [2:0]  gnt3;
  logic        busy3;

  int n_checks = 0;
  int n_pass   = 0;
  int exp2[$];
  int exp3[$];

  int m_grant[2];
  int m_last[2];
  int m_cnt[2];
  int MN[2] = '{2, 3};
  int MX[2] = '{4, 1};

  always #5 clk = ~clk;

  avalon_rr_arbiter #(.NUM_INPUTS(2), .SEL_NUM_BITS(5), .SEL_VAL(0), .MAX_XFERS(4)) dut2 (
    .i_Clk(clk), .i_Reset(rst), .i_AVIn_Addr(addr2), .i_AVIn_Read(rd2),
    .i_AVIn_Write(wr2), .i_AVOut_WaitRequest(wt2),
    .o_MuxSel(sel2), .o_Grant(gnt2), .o_Busy(busy2));

  avalon_rr_arbiter #(.NUM_INPUTS(3), .SEL_NUM_BITS(5), .SEL_VAL(0), .MAX_XFERS(1)) dut3 (
    .i_Clk(clk), .i_Reset(rst), .i_AVIn_Addr(addr3), .i_AVIn_Read(rd3),
    .i_AVIn_Write(wr3), .i_AVOut_WaitRequest(wt3),
    .o_MuxSel(sel3), .o_Grant(gnt3), .o_Busy(busy3));

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int pick(int d, int excl, logic [2:0] el);
    for (int off = 1; off <= MN[d]; off++) begin
      int i;
      i = (m_last[d] + off) % MN[d];
      if (el[i] && i != excl) return i;
    end
    return -1;
  endfunction

  // Reference: grant index or -1 for none, advanced once per clock edge.
  task automatic model_step(int d, logic [2:0] el, logic wt, logic r);
    int w, c;
    if (r) begin
      m_grant[d] = -1; m_last[d] = MN[d] - 1; m_cnt[d] = 0;
    end else if (m_grant[d] < 0) begin
      w = pick(d, -1, el);
      if (w >= 0) begin m_grant[d] = w; m_last[d] = w; m_cnt[d] = 0; end
    end else if (el[m_grant[d]] && !wt) begin
      c = (m_cnt[d] >= 255) ? 255 : m_cnt[d] + 1;
      w = pick(d, m_grant[d], el);
      if (c >= MX[d] && w >= 0) begin m_grant[d] = w; m_last[d] = w; m_cnt[d] = 0; end
      else m_cnt[d] = c;
    end else if (!el[m_grant[d]]) begin
      w = pick(d, m_grant[d], el);
      m_cnt[d] = 0;
      if (w >= 0) begin m_grant[d] = w; m_last[d] = w; end
      else m_grant[d] = -1;
    end
  endtask

  function automatic logic [2:0] elig2();
    logic [2:0] e = '0;
    for (int k = 0; k < 2; k++) e[k] = (rd2[k] | wr2[k]) && (addr2[30*k+25 +: 5] == 5'd0);
    return e;
  endfunction

  function automatic logic [2:0] elig3();
    logic [2:0] e = '0;
    for (int k = 0; k < 3; k++) e[k] = (rd3[k] | wr3[k]) && (addr3[30*k+25 +: 5] == 5'd0);
    return e;
  endfunction

  // Inputs are already applied at a falling edge; predict the next rising edge.
  task automatic step();
    model_step(0, elig2(), wt2, rst);
    model_step(1, elig3(), wt3, rst);
    exp2.push_back(m_grant[0]);
    exp3.push_back(m_grant[1]);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp2.size() > 0) begin
        int g;
        g = exp2.pop_front();
        check("sel2", int'(sel2), (g < 0) ? 2 : g);
        check("gnt2", int'(gnt2), (g < 0) ? 0 : (1 << g));
        check("busy2", int'(busy2), (g >= 0) ? 1 : 0);
      end
      if (exp3.size() > 0) begin
        int g;
        g = exp3.pop_front();
        check("sel3", int'(sel3), (g < 0) ? 3 : g);
        check("gnt3", int'(gnt3), (g < 0) ? 0 : (1 << g));
        check("busy3", int'(busy3), (g >= 0) ? 1 : 0);
      end
    end
  end

  initial begin
    int bad;
    int seq2[5] = '{0, 0, 0, 0, 1};
    rst = 1'b1;
    addr2 = '0; rd2 = '0; wr2 = '0; wt2 = 1'b0;
    addr3 = '0; rd3 = '0; wr3 = '0; wt3 = 1'b0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) step();
    check("reset_idle_sel", int'(sel2), 2);
    check("reset_idle_busy", int'(busy2), 0);

    // Both masters read; master 0 takes 4 transfers, then master 1 with no gap
    rd2 = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      check("quantum_seq", int'(sel2), seq2[i]);
    end
    rd2 = 2'b00;
    step(); step(); step();

    // Master 1 write stalled by wait-request while master 0 requests
    wr2 = 2'b10; wt2 = 1'b1;
    step();
    check("m1_granted", int'(sel2), 1);
    rd2 = 2'b01;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sel2 != 2'd1) bad++;
    end
    check("hold_during_wait", bad, 0);
    wt2 = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rd2 = 2'b00; wr2 = 2'b00;
    step(); step();

    // Address decoding to another slave is never granted
    rd2 = 2'b01; addr2[29:25] = 5'd3;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy2) bad++;
    end
    check("wrong_slave_idle", bad, 0);
    rd2 = 2'b00; addr2 = '0;

    // Three masters, quantum 1: strict rotation 0,1,2,0,1,2
    rst = 1'b1; step(); rst = 1'b0;
    rd3 = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rot3_seq", int'(sel3), i % 3);
    end
    rd3 = 3'b000;
    step(); step();

    // Reset while master 1 is granted and stalled
    rst = 1'b1; step(); rst = 1'b0;
    wr2 = 2'b10; wt2 = 1'b1;
    step(); step();
    check("pre_reset_grant", int'(sel2), 1);
    rd2 = 2'b01; rst = 1'b1;
    step();
    check("reset_mid_sel", int'(sel2), 2);
    rst = 1'b0;
    step();
    check("regrant_after_reset", int'(sel2), 0);

    // Random traffic with sticky requests
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 255) == 0);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) == 0) rd2[k] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) wr2[k] = 1'($urandom_range(0, 1));
        addr2[30*k +: 25] = 25'($urandom);
        if ($urandom_range(0, 3) == 0) addr2[30*k+25 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd3 : 5'd0;
      end
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) rd3[k] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) wr3[k] = 1'($urandom_range(0, 1));
        addr3[30*k +: 25] = 25'($urandom);
        if ($urandom_range(0, 3) == 0) addr3[30*k+25 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd1 : 5'd0;
      end
      wt2 = 1'($urandom_range(0, 1));
      wt3 = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_rr_arbiter.md
# avalon_rr_arbiter

Round-robin arbiter that shares one Avalon slave port among `NUM_INPUTS` masters. It decodes which master requests target this slave, grants one master at a time, and holds the grant for the whole wait-request handshake. It caps consecutive transfers per master with a quantum and drives the mux select of the existing bus mux in the interconnect. There is one instance per slave port.

## Interface
- `NUM_INPUTS`, 2: number of masters, minimum 2.
- `SEL_NUM_BITS`, 5: number of upper address bits used for slave decode.
- `SEL_VAL`, 0: decode value that selects this slave.
- `MAX_XFERS`, 4: consecutive completed transfers one master may take while another eligible master waits. Range 1..255.

Ports:
- `i_Clk`  in  1  the single clock.
- `i_Reset`  in  1  reset, synchronous and active-high.
- `i_AVIn_Addr`  in  30*NUM_INPUTS  word addresses of the masters; master k uses bits [30k+29:30k].
- `i_AVIn_Read`  in  NUM_INPUTS  read strobes, one per master.
- `i_AVIn_Write`  in  NUM_INPUTS  write strobes, one per master.
- `i_AVOut_WaitRequest`  in  1  wait request from the slave.
- `o_MuxSel`  out  $clog2(NUM_INPUTS+1)  index of the granted master. The value NUM_INPUTS means no grant.
- `o_Grant`  out  NUM_INPUTS  one-hot grant. All zeros when `o_MuxSel` equals NUM_INPUTS.
- `o_Busy`  out  1  high while any grant is held.

## Operation
- Eligible request for master k: (Read[k] | Write[k]) & (Addr_k[29 -: SEL_NUM_BITS] == SEL_VAL).
- Transfer completion: the granted master is eligible and `i_AVOut_WaitRequest` is 0 at a rising edge.
- Registers:
  - `grant_idx`: output directly as `o_MuxSel`.
  - `last_idx`: index of the last master granted.
  - `xfer_cnt`: 8 bits.
- Round-robin search: scan indices last_idx+1, last_idx+2, … modulo NUM_INPUTS, and take the first eligible master.
- Reset values:
  - `o_MuxSel` = NUM_INPUTS, `o_Grant` = 0, `o_Busy` = 0.
  - `last_idx` = NUM_INPUTS-1, so master 0 wins first.
  - `xfer_cnt` = 0.
- State IDLE (no grant):
  - If any master is eligible, grant the RR winner at the next edge, set `last_idx` to the winner, clear `xfer_cnt`, and go to GRANTED.
  - Otherwise stay in IDLE.
- State GRANTED, master g, evaluated each edge in this priority order:
  1. Completion this cycle: `xfer_cnt` +1, saturating at 255. If the new count is ≥ MAX_XFERS and another master is eligible, grant that master (RR search, skipping g), clear `xfer_cnt`, and set `last_idx`. Otherwise keep g.
  2. g is not eligible (request dropped, or the next request decodes to another slave): grant the RR winner among the others and clear `xfer_cnt`. If no other master is eligible, go to IDLE (`o_MuxSel` = NUM_INPUTS).
  3. g is eligible and waiting: hold the grant unchanged.
- Grant never changes while the granted master has an eligible request with `i_AVOut_WaitRequest` = 1, which keeps transfers atomic.
- A master that is not granted sees wait-request asserted through the mux. The arbiter does not drive wait-request.
- Eligibility of other masters is sampled only when a rotation decision is made. No request is latched.

## Timing
- Grant latency: an eligible request in IDLE at cycle N produces `o_MuxSel`/`o_Grant` valid in cycle N+1, and the slave sees the request in N+1.
- Back-to-back transfers by the same master under the quantum: no bubble cycles.
- Rotation on completion: the new master is granted in the cycle after the completing edge, with zero idle cycles between masters.
- Release after the granted master drops its request: one cycle of stale grant (the cycle the drop is seen), then regrant or IDLE.
- Simultaneous requests from all masters in IDLE: the lowest index after `last_idx` wins.
- Reset mid-transfer: grant is forced to none at the reset edge, and an in-flight slave transfer is abandoned. Reset has priority over every transition.
- MAX_XFERS = 1: the grant rotates after every completion whenever another master is eligible.
- Outputs are fully registered, with no combinational path from any input to any output.

## Test plan
- Reset release with no requests: `o_MuxSel` = 2, `o_Grant` = 00, `o_Busy` = 0 for 10 cycles (NUM_INPUTS = 2).
- Master 0 and master 1 both read with matching addresses (top 5 bits = 0) at cycle 5: master 0 is granted in cycle 6. After master 0 completes 4 transfers with waitrequest = 0, master 1 is granted in the next cycle with no gap.
- Master 1 holds a write with `i_AVOut_WaitRequest` = 1 for 20 cycles while master 0 requests: `o_MuxSel` stays 1 throughout, and the switch to master 0 happens only after waitrequest drops and the quantum or the request drop allows it.
- Master 0 request with address top bits = 3 (SEL_VAL = 0): never granted, and the arbiter stays in IDLE.
- NUM_INPUTS = 3, all masters requesting continuously, MAX_XFERS = 1: grant sequence is 0, 1, 2, 0, 1, 2, … with one completion each.
- `i_Reset` asserted for 1 cycle while master 1 is granted and waiting: `o_MuxSel` = NUM_INPUTS in the next cycle, then master 0 wins the regrant if it is requesting.
